keccak_byte_packer: RTL and testbench
=====================================

# keccak_byte_packer

Upstream feeder for the `keccak` core. It accepts a message as a byte stream, packs bytes big-endian into 32-bit words, and drives the core's `in` / `in_ready` / `is_last` / `byte_num` inputs while obeying `buffer_full`. It pulses the core's reset before each message and waits for `out_ready` before starting the next one, so software or a DMA engine only supplies bytes.

## Interface
- No parameters; all widths are fixed by the `keccak` core contract.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- `s_byte`  in  8  message byte.
- `s_valid`  in  1  `s_byte`, `s_last` and `s_empty` are valid.
- `s_last`  in  1  this beat ends the message.
- `s_empty`  in  1  with `s_last`: terminator beat that carries no data byte (ignore `s_byte`).
- `s_ready`  out  1  a beat transfers on a rising edge with `s_valid & s_ready`.
- `k_reset`  out  1  one-cycle active-high pulse to the core's `reset`.
- `k_in`  out  32  the core's `in`; first byte in [31:24]; unused low bytes are 0.
- `k_in_ready`  out  1  the core's `in_ready`.
- `k_is_last`  out  1  the core's `is_last`.
- `k_byte_num`  out  2  the core's `byte_num`: valid bytes in the last word, 0..3.
- `k_buffer_full`  in  1  from the core; stalls word transfer.
- `k_out_ready`  in  1  from the core; digest available.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, FILL, SEND, SEND_PAD, WAIT_DIGEST.
- **IDLE**
  - `s_ready`=0.
  - `s_valid`=1 → CLEAR. The beat is not consumed.
- **CLEAR**
  - `k_reset`=1 for exactly one cycle.
  - Clear the accumulator and the byte count `cnt` (2 bits).
  - → FILL.
- **FILL**
  - `s_ready`=1.
  - On a data beat, shift the byte into the accumulator at position `cnt` and set n = `cnt`+1.
  - Not last, n<4: stay in FILL.
  - Not last, n=4: latch the word with `k_is_last`=0 → SEND.
  - Last, n<4: latch the word with `k_is_last`=1 and `k_byte_num`=n → SEND.
  - Last, n=4: latch the full word with `k_is_last`=0 and set `pad_pending` → SEND.
  - Empty terminator: latch the accumulated partial word with `k_is_last`=1 and `k_byte_num`=`cnt` → SEND. If `cnt`=0, the word is 0x00000000.
- **SEND**
  - `s_ready`=0, `k_in_ready`=1, outputs held stable.
  - The word transfers on an edge with `k_buffer_full`=0.
  - After the transfer:
    - `pad_pending` set → SEND_PAD.
    - `k_is_last` was 1 → WAIT_DIGEST.
    - Otherwise → FILL, with `cnt`=0.
- **SEND_PAD**
  - Drive `k_in`=0, `k_byte_num`=0, `k_is_last`=1, `k_in_ready`=1.
  - Transfers under the same rule as SEND, then → WAIT_DIGEST.
- **WAIT_DIGEST**
  - `s_ready`=0, `k_in_ready`=0.
  - `k_out_ready`=1 → IDLE.
- `k_byte_num` is 0 on every non-final word. On a final word it equals the number of valid bytes (0..3).
- A message whose length is a multiple of 4 always ends with an all-zero word carrying `k_is_last`=1.

## Timing
- Reset values: `s_ready`=0, `k_reset`=0, `k_in`=0, `k_in_ready`=0, `k_is_last`=0, `k_byte_num`=0, `busy`=0, state IDLE.
- Reset deasserting takes effect at the next rising edge.
- Start of message: `s_valid` rises in IDLE at edge E.
  - `k_reset` is high in cycle E+1.
  - `s_ready` is high from cycle E+2.
- Word latency: the 4th byte is accepted at edge N.
  - `k_in_ready` is high in cycle N+1.
  - With no stall, the transfer happens at edge N+1.
  - `s_ready` is high again in cycle N+2.
- Stall: while `k_buffer_full`=1, `k_in`, `k_is_last` and `k_byte_num` hold and `k_in_ready` stays 1. No byte is lost or duplicated.
- `k_in_ready` is never high in the same cycle as `k_reset`.
- `k_in_ready` is low in every state except SEND and SEND_PAD.
- Reset mid-operation, in any state: outputs go to their reset values asynchronously and the partial message is discarded. The next message starts with a fresh CLEAR.
- `s_valid` held during WAIT_DIGEST: the beat is not consumed until after IDLE → CLEAR.

## Test plan
- "Hello, world!" (13 bytes)
  - Four words: 0x48656C6C, 0x6F2C2077 and 0x6F726C64 with `k_is_last`=0, then 0x21000000 with `k_byte_num`=1 and `k_is_last`=1.
  - Exactly one `k_reset` pulse, before the first word.
- "Hello, world" (12 bytes, last on 'd')
  - Three words with `k_is_last`=0, then 0x00000000 with `k_byte_num`=0 and `k_is_last`=1, via SEND_PAD.
- Empty message (a single beat with `s_last`=1 and `s_empty`=1)
  - A `k_reset` pulse, then one word 0x00000000 with `k_byte_num`=0 and `k_is_last`=1.
  - Then WAIT_DIGEST; `busy` stays 1 until `k_out_ready`.
- Backpressure: `k_buffer_full`=1 for 5 cycles during the second word of "The quick"
  - `k_in`=0x71756963 held for 5 cycles, `s_ready`=0, transfer on the first edge with full=0.
  - The word sequence is identical to the unstalled run.
- Reset pulled low mid-FILL after 2 bytes
  - All outputs read 0 in the same cycle.
  - Resending "Hello, world!" reproduces the words of the first scenario exactly.
- Back-to-back "1234567890" then "password123"
  - The second message's bytes are not accepted until `k_out_ready`=1.
  - A new `k_reset` pulse precedes the second message's first word, 0x70617373.

Source files
------------

// File: rtl/keccak_byte_packer.sv
// Byte-stream front end for the keccak core: packs bytes big-endian into 32-bit
// words, drives the core's word handshake and resets it before every message.
module keccak_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic        s_empty,
    output logic        s_ready,
    output logic        k_reset,
    output logic [31:0] k_in,
    output logic        k_in_ready,
    output logic        k_is_last,
    output logic [1:0]  k_byte_num,
    input  logic        k_buffer_full,
    input  logic        k_out_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL,
        SEND,
        SEND_PAD,
        WAIT_DIGEST
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pad_pending_q, pad_pending_d;
    logic [31:0] k_in_q, k_in_d;
    logic        k_is_last_q, k_is_last_d;
    logic [1:0]  k_byte_num_q, k_byte_num_d;
    logic        s_ready_q, s_ready_d;
    logic        k_reset_q, k_reset_d;
    logic        k_in_ready_q, k_in_ready_d;
    logic        busy_q, busy_d;

    logic [31:0] word;
    logic [2:0]  n;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        k_in_d        = k_in_q;
        k_is_last_d   = k_is_last_q;
        k_byte_num_d  = k_byte_num_q;
        n             = {1'b0, cnt_q} + 3'd1;

        // Accumulator with the incoming byte dropped into its big-endian slot
        word = acc_q;
        case (cnt_q)
            2'd0:    word[31:24] = s_byte;
            2'd1:    word[23:16] = s_byte;
            2'd2:    word[15:8]  = s_byte;
            default: word[7:0]   = s_byte;
        endcase

        case (state_q)
            IDLE: begin
                if (s_valid) state_d = CLEAR;
            end
            CLEAR: begin
                acc_d         = '0;
                cnt_d         = '0;
                pad_pending_d = 1'b0;
                k_in_d        = '0;
                k_is_last_d   = 1'b0;
                k_byte_num_d  = '0;
                state_d       = FILL;
            end
            FILL: begin
                if (s_valid) begin
                    if (s_last && s_empty) begin
                        k_in_d       = acc_q;
                        k_is_last_d  = 1'b1;
                        k_byte_num_d = cnt_q;
                        state_d      = SEND;
                    end else if (s_last || n == 3'd4) begin
                        k_in_d        = word;
                        k_is_last_d   = s_last && (n != 3'd4);
                        k_byte_num_d  = (s_last && (n != 3'd4)) ? n[1:0] : 2'd0;
                        pad_pending_d = s_last && (n == 3'd4);
                        state_d       = SEND;
                    end else begin
                        acc_d = word;
                        cnt_d = n[1:0];
                    end
                end
            end
            SEND: begin
                if (!k_buffer_full) begin
                    if (pad_pending_q) begin
                        // A length that is a multiple of 4 still needs an empty final word
                        pad_pending_d = 1'b0;
                        k_in_d        = '0;
                        k_is_last_d   = 1'b1;
                        k_byte_num_d  = '0;
                        state_d       = SEND_PAD;
                    end else if (k_is_last_q) begin
                        state_d = WAIT_DIGEST;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            SEND_PAD: begin
                if (!k_buffer_full) state_d = WAIT_DIGEST;
            end
            WAIT_DIGEST: begin
                if (k_out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        s_ready_d    = (state_d == FILL);
        k_reset_d    = (state_d == CLEAR);
        k_in_ready_d = (state_d == SEND) || (state_d == SEND_PAD);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            k_in_q        <= '0;
            k_is_last_q   <= 1'b0;
            k_byte_num_q  <= '0;
            s_ready_q     <= 1'b0;
            k_reset_q     <= 1'b0;
            k_in_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            k_in_q        <= k_in_d;
            k_is_last_q   <= k_is_last_d;
            k_byte_num_q  <= k_byte_num_d;
            s_ready_q     <= s_ready_d;
            k_reset_q     <= k_reset_d;
            k_in_ready_q  <= k_in_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign k_reset    = k_reset_q;
    assign k_in       = k_in_q;
    assign k_in_ready = k_in_ready_q;
    assign k_is_last  = k_is_last_q;
    assign k_byte_num = k_byte_num_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Bench for keccak_byte_packer: directed messages plus random ones, each checked
// against word lists built straight from the message bytes.
module tb_keccak_byte_packer;

    typedef logic [7:0] byte_q_t[$];

    typedef struct packed {
        logic [31:0] word;
        logic        last;
        logic [1:0]  bn;
        logic        pad_next;
    } exp_word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_last;
    logic        s_empty;
    logic        s_ready;
    logic        k_reset;
    logic [31:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [1:0]  k_byte_num;
    logic        k_buffer_full;
    logic        k_out_ready;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    exp_word_t exp_q[$];

    keccak_byte_packer dut (
        .clk          (clk),
        .reset        (reset),
        .s_byte       (s_byte),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_empty      (s_empty),
        .s_ready      (s_ready),
        .k_reset      (k_reset),
        .k_in         (k_in),
        .k_in_ready   (k_in_ready),
        .k_is_last    (k_is_last),
        .k_byte_num   (k_byte_num),
        .k_buffer_full(k_buffer_full),
        .k_out_ready  (k_out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic byte_q_t str2q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: groups of four bytes, then a final partial (possibly empty) word
    task automatic build_expected(input byte_q_t msg, input bit use_empty);
        int len;
        int r;
        exp_word_t e;
        len = msg.size();
        exp_q.delete();
        for (int w = 0; w < len / 4; w++) begin
            e.word     = {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
            e.last     = 1'b0;
            e.bn       = 2'd0;
            e.pad_next = !use_empty && (len % 4 == 0) && (w == len / 4 - 1);
            exp_q.push_back(e);
        end
        r = len % 4;
        e.word = 32'h0;
        for (int i = 0; i < r; i++) e.word = e.word | (32'(msg[len - r + i]) << (24 - 8 * i));
        e.last     = 1'b1;
        e.bn       = 2'(r);
        e.pad_next = 1'b0;
        exp_q.push_back(e);
    endtask

    // Sends one message from IDLE, checks every word transfer, then completes the digest handshake
    task automatic applyStimulus(input byte_q_t msg, input bit use_empty, input int stall_mode);
        logic [7:0]  bb[$];
        bit          bl[$];
        bit          be[$];
        int          bi = 0, wi = 0, cyc = 0, resets = 0, group = 0, stall_left = 0;
        bit          done = 0, exp_send_next = 0, exp_fill_next = 0, prev_stalled = 0, stall_done = 0;
        logic [31:0] prev_k_in = '0;

        if (msg.size() == 0) use_empty = 1;
        build_expected(msg, use_empty);
        for (int i = 0; i < msg.size(); i++) begin
            bb.push_back(msg[i]);
            bl.push_back(!use_empty && (i == msg.size() - 1));
            be.push_back(1'b0);
        end
        if (use_empty) begin
            bb.push_back(8'($urandom_range(0, 255)));
            bl.push_back(1'b1);
            be.push_back(1'b1);
        end

        while (!done && cyc < 2000) begin
            @(negedge clk);
            if (k_reset) begin
                resets++;
                if (resets == 1) checkOutput("k_reset_cycle", cyc, 1);
                checkOutput("k_reset_vs_in_ready", k_in_ready, 0);
                checkOutput("k_reset_before_words", wi, 0);
            end
            if (cyc == 2) checkOutput("s_ready_start", s_ready, 1);
            if (exp_send_next) checkOutput("word_latency", k_in_ready, 1);
            if (exp_fill_next) checkOutput("refill_ready", s_ready, 1);
            if (prev_stalled) begin
                checkOutput("stall_in_ready", k_in_ready, 1);
                checkOutput("stall_k_in_hold", k_in, prev_k_in);
            end
            checkOutput("s_ready_vs_in_ready", s_ready & k_in_ready, 0);
            exp_send_next = 0;
            exp_fill_next = 0;

            case (stall_mode)
                1: k_buffer_full = ($urandom_range(0, 2) == 0);
                2: begin
                    if (k_in_ready && wi == 1 && !stall_done && stall_left == 0) stall_left = 5;
                    k_buffer_full = (stall_left > 0);
                    if (stall_left > 0) begin
                        stall_left--;
                        if (stall_left == 0) stall_done = 1;
                    end
                end
                default: k_buffer_full = 1'b0;
            endcase

            if (bi < bb.size()) begin
                s_valid = (bi == 0) || ($urandom_range(0, 3) != 0);
                s_byte  = bb[bi];
                s_last  = bl[bi];
                s_empty = be[bi];
                if (s_valid && s_ready) begin
                    if (!be[bi]) group++;
                    if (be[bi] || bl[bi] || group == 4) begin
                        exp_send_next = 1;
                        group = 0;
                    end
                    bi++;
                end
            end else begin
                s_valid = 1'b1;
                s_byte  = 8'($urandom_range(0, 255));
                s_last  = 1'b0;
                s_empty = 1'b0;
                checkOutput("no_extra_beat", s_ready, 0);
            end

            if (k_in_ready && !k_buffer_full) begin
                if (wi < exp_q.size()) begin
                    checkOutput("k_in", k_in, exp_q[wi].word);
                    checkOutput("k_is_last", k_is_last, exp_q[wi].last);
                    checkOutput("k_byte_num", k_byte_num, exp_q[wi].bn);
                    if (!exp_q[wi].last && !exp_q[wi].pad_next) exp_fill_next = 1;
                    wi++;
                    if (wi == exp_q.size()) done = 1;
                end else begin
                    checkOutput("extra_word", wi, exp_q.size());
                end
            end
            prev_stalled = k_in_ready && k_buffer_full;
            prev_k_in    = k_in;
            cyc++;
        end
        checkOutput("timeout", done, 1);
        checkOutput("beats_consumed", bi, bb.size());

        repeat (3) begin
            @(negedge clk);
            checkOutput("wait_busy", busy, 1);
            checkOutput("wait_in_ready", k_in_ready, 0);
            checkOutput("wait_s_ready", s_ready, 0);
            if (k_reset) resets++;
        end
        k_out_ready = 1'b1;
        @(negedge clk);
        k_out_ready = 1'b0;
        s_valid     = 1'b0;
        checkOutput("idle_busy", busy, 0);
        checkOutput("k_reset_count", resets, 1);
    endtask

    initial begin
        reset         = 1'b0;
        s_byte        = '0;
        s_valid       = 1'b0;
        s_last        = 1'b0;
        s_empty       = 1'b0;
        k_buffer_full = 1'b0;
        k_out_ready   = 1'b0;

        #12;
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_k_reset", k_reset, 0);
        checkOutput("rst_k_in", k_in, 0);
        checkOutput("rst_k_in_ready", k_in_ready, 0);
        checkOutput("rst_k_is_last", k_is_last, 0);
        checkOutput("rst_k_byte_num", k_byte_num, 0);
        checkOutput("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(str2q("Hello, world!"), 0, 0);
        applyStimulus(str2q("Hello, world"), 0, 0);
        applyStimulus(str2q(""), 1, 0);
        applyStimulus(str2q("The quick"), 0, 2);

        // Abort a message after two bytes with an asynchronous reset
        @(negedge clk);
        s_valid = 1'b1;
        s_byte  = "H";
        s_last  = 1'b0;
        s_empty = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_fill_ready", s_ready, 1);
        @(negedge clk);
        s_byte = "e";
        @(negedge clk);
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("async_s_ready", s_ready, 0);
        checkOutput("async_k_reset", k_reset, 0);
        checkOutput("async_k_in", k_in, 0);
        checkOutput("async_k_in_ready", k_in_ready, 0);
        checkOutput("async_k_is_last", k_is_last, 0);
        checkOutput("async_k_byte_num", k_byte_num, 0);
        checkOutput("async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(str2q("Hello, world!"), 0, 0);
        applyStimulus(str2q("1234567890"), 0, 1);
        applyStimulus(str2q("password123"), 0, 1);

        for (int m = 0; m < 8; m++) begin
            byte_q_t msg;
            int len;
            len = $urandom_range(0, 20);
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
            applyStimulus(msg, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
